// File: rtl/ticket_pkg.sv
// ticket_pkg: items shared by the ticket payout block.
// Contents:
//   - The payout FSM state enum. Its encoding is visible on the st debug output.
//   - The coin denominations, which are 2 units and 1 unit.
//   - Default values for the COIN_GAP and TKT_TIMEOUT parameters.
//   - Helper functions that split an amount into a coin count and pick the
//     next coin state.
package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRINT = 3'd2,
    ST_COIN2 = 3'd3,
    ST_COIN1 = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam int COIN2_VAL = 2;
  localparam int COIN1_VAL = 1;

  localparam int DEF_COIN_GAP    = 3;
  localparam int DEF_TKT_TIMEOUT = 20;

  // Number of 2-unit coins for a 3-bit amount. The divisor is a constant,
  // so this reduces to a shift.
  function automatic logic [1:0] coins2_of(input logic [2:0] amount);
    return 2'(32'(amount) / COIN2_VAL);
  endfunction

  // Number of 1-unit coins left after the 2-unit coins are paid.
  function automatic logic coins1_of(input logic [2:0] amount);
    return 1'((32'(amount) % COIN2_VAL) / COIN1_VAL);
  endfunction

  // Coin ordering: every 2-unit coin is paid first, then the 1-unit coin,
  // then the FSM returns to idle.
  function automatic state_e next_coin(input logic [1:0] n2, input logic n1);
    if (n2 != 2'd0) return ST_COIN2;
    else if (n1) return ST_COIN1;
    else return ST_IDLE;
  endfunction

endpackage

// File: rtl/ticket_payout_if.sv
// ticket_payout_if: groups the signals between the ticket FSM, the printer
// and the coin hopper around the ticket_payout block.
// Optional feature macro: PAYOUT_SALES_COUNT_EN. When it is defined, the
// interface also carries sales_cnt.
//
// Signals:
//   y          ticket-issued level. Its rising edge queues one transaction.
//   re[2:0]    change owed. It is sampled only in the cycle y rises.
//   tkt_ack    printer acknowledge.
//   tkt_fire   print request.
//   coin2_fire one-cycle pulse that ejects one 2-unit coin.
//   coin1_fire one-cycle pulse that ejects one 1-unit coin.
//   busy       high while a transaction is active or queued.
//   ovf        one-cycle pulse when a capture is dropped.
//   fault      sticky printer-timeout flag.
//   st[2:0]    current FSM state, for debug.
//
// Print handshake: tkt_fire is a request that stays high until the cycle in
// which tkt_ack is seen high at a rising edge, or until the timeout expires.
// The transfer completes on that edge and tkt_fire is low in the next cycle.
// tkt_ack has no meaning while tkt_fire is low.
interface ticket_payout_if;
  logic       y;
  logic [2:0] re;
  logic       tkt_ack;
  logic       tkt_fire;
  logic       coin2_fire;
  logic       coin1_fire;
  logic       busy;
  logic       ovf;
  logic       fault;
  logic [2:0] st;
`ifdef PAYOUT_SALES_COUNT_EN
  logic [15:0] sales_cnt;

  modport master (
    output y, re, tkt_ack,
    input  tkt_fire, coin2_fire, coin1_fire, busy, ovf, fault, st, sales_cnt
  );
  modport slave (
    input  y, re, tkt_ack,
    output tkt_fire, coin2_fire, coin1_fire, busy, ovf, fault, st, sales_cnt
  );
`else
  modport master (
    output y, re, tkt_ack,
    input  tkt_fire, coin2_fire, coin1_fire, busy, ovf, fault, st
  );
  modport slave (
    input  y, re, tkt_ack,
    output tkt_fire, coin2_fire, coin1_fire, busy, ovf, fault, st
  );
`endif
endinterface

// File: rtl/payout_fifo.sv
// payout_fifo: synchronous FIFO with 2 entries of W bits. It holds the
// amounts owed for queued transactions.
// Ports:
//   clk, rst  clock and synchronous active-high reset. Reset empties the FIFO.
//   push_i    write din_i. The caller must only push when the FIFO is not
//             full, or when it pops in the same cycle.
//   pop_i     drop the head entry. The caller must only pop when the FIFO is
//             not empty.
//   din_i     data to write.
//   dout_o    head entry. It is valid while empty_o is low.
//   full_o    high when 2 entries are held.
//   empty_o   high when no entries are held.
module payout_fifo #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      // When the FIFO is full, a push and a pop in the same cycle leave the
      // count unchanged. The new data goes into the slot being vacated.
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ticket_payout.sv
// ticket_payout: pays out a ticket plus the change owed. A rising edge on y
// queues the amount re. Each queued transaction then produces:
//   - one print request (tkt_fire), followed by
//   - one 2-unit coin pulse per 2 units of change, then
//   - one 1-unit coin pulse if the change is odd.
// After every coin pulse the FSM stays idle for COIN_GAP cycles.
// Optional feature macro: PAYOUT_SALES_COUNT_EN. When it is defined, the
// block also drives sales_cnt, a saturating count of completed print phases.
// Ports:
//   clk        single clock. All logic runs on its rising edge.
//   rst        synchronous active-high reset. It abandons any payout in
//              progress.
//   bus        ticket_payout_if.slave. Carries y, re, tkt_ack in and
//              tkt_fire, coin2_fire, coin1_fire, busy, ovf, fault, st
//              (and sales_cnt when enabled) out.
// Parameters:
//   COIN_GAP     idle cycles after each coin pulse (1..15).
//   TKT_TIMEOUT  maximum number of cycles tkt_fire waits for tkt_ack (2..255).
module ticket_payout
  import ticket_pkg::*;
#(
  parameter int COIN_GAP    = DEF_COIN_GAP,
  parameter int TKT_TIMEOUT = DEF_TKT_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  ticket_payout_if.slave bus
);

  localparam logic [3:0] GAP_LAST = 4'(COIN_GAP - 1);
  localparam logic [7:0] TMO_LAST = 8'(TKT_TIMEOUT - 1);

  // Capture and queue
  logic       y_q;
  logic       cap;
  logic       push;
  logic       pop;
  logic [2:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  // Only the rising edge of y counts, so a level held high queues once.
  assign cap = bus.y & ~y_q;
  // When the FIFO is full, a capture is accepted only if the FSM pops in the
  // same cycle.
  assign push = cap & (~fifo_full | pop);

  payout_fifo #(.W(3)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.re),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM and counters
  state_e     state_q, state_d;
  logic [2:0] cur_re_q, cur_re_d;
  logic [1:0] n2_q, n2_d;
  logic       n1_q, n1_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] tmo_q, tmo_d;
  logic       print_exit;
  logic       tmo_hit;

  always_comb begin
    state_d    = state_q;
    cur_re_d   = cur_re_q;
    n2_d       = n2_q;
    n1_d       = n1_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    print_exit = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_re_d = fifo_dout;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        n2_d    = coins2_of(cur_re_q);
        n1_d    = coins1_of(cur_re_q);
        tmo_d   = 8'd0;
        state_d = ST_PRINT;
      end
      ST_PRINT: begin
        // A timeout is handled like an ack, so the change is still paid.
        // If tkt_ack arrives in the last cycle, the ack wins and no fault
        // is raised.
        if (bus.tkt_ack || (tmo_q == TMO_LAST)) begin
          print_exit = 1'b1;
          tmo_hit    = ~bus.tkt_ack;
          state_d    = next_coin(n2_q, n1_q);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_COIN2: begin
        n2_d    = n2_q - 2'd1;
        gap_d   = 4'd0;
        state_d = ST_GAP;
      end
      ST_COIN1: begin
        n1_d    = 1'b0;
        gap_d   = 4'd0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = next_coin(n2_q, n1_q);
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs
  logic tkt_fire_q;
  logic coin2_fire_q;
  logic coin1_fire_q;
  logic ovf_q;
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q          <= 1'b0;
      state_q      <= ST_IDLE;
      cur_re_q     <= 3'd0;
      n2_q         <= 2'd0;
      n1_q         <= 1'b0;
      gap_q        <= 4'd0;
      tmo_q        <= 8'd0;
      tkt_fire_q   <= 1'b0;
      coin2_fire_q <= 1'b0;
      coin1_fire_q <= 1'b0;
      ovf_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      y_q          <= bus.y;
      state_q      <= state_d;
      cur_re_q     <= cur_re_d;
      n2_q         <= n2_d;
      n1_q         <= n1_d;
      gap_q        <= gap_d;
      tmo_q        <= tmo_d;
      // Each fire output is decoded from the next state, so it is exactly
      // the registered image of "currently in that state".
      tkt_fire_q   <= (state_d == ST_PRINT);
      coin2_fire_q <= (state_d == ST_COIN2);
      coin1_fire_q <= (state_d == ST_COIN1);
      ovf_q        <= cap & fifo_full & ~pop;
      fault_q      <= fault_q | tmo_hit;
    end
  end

  assign bus.tkt_fire   = tkt_fire_q;
  assign bus.coin2_fire = coin2_fire_q;
  assign bus.coin1_fire = coin1_fire_q;
  assign bus.ovf        = ovf_q;
  assign bus.fault      = fault_q;
  assign bus.busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign bus.st         = state_q;

`ifdef PAYOUT_SALES_COUNT_EN
  logic [15:0] sales_q;

  always_ff @(posedge clk) begin
    if (rst) sales_q <= 16'd0;
    else if (print_exit && (sales_q != 16'hFFFF)) sales_q <= sales_q + 16'd1;
  end

  assign bus.sales_cnt = sales_q;
`endif

endmodule

// File: tb/tb_ticket_payout.sv
// tb_ticket_payout: directed bench for ticket_payout with event scoreboard.
// Optional feature macro: PAYOUT_SALES_COUNT_EN (adds sales_cnt checks).
module tb_ticket_payout;

  localparam logic [3:0] K_TR    = 4'd1; // tkt_fire rises
  localparam logic [3:0] K_TF    = 4'd2; // tkt_fire falls
  localparam logic [3:0] K_C2    = 4'd3; // coin2_fire high
  localparam logic [3:0] K_C1    = 4'd4; // coin1_fire high
  localparam logic [3:0] K_OVF   = 4'd5; // ovf high
  localparam logic [3:0] K_FAULT = 4'd6; // fault rises
  localparam logic [3:0] K_BF    = 4'd7; // busy falls

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ack_at = 2;
  int   fire_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_tkt, prev_busy, prev_fault;
  int   exp_sales = 0;

  // Event word: {kind[3:0], absolute cycle[27:0]}
  logic [31:0] exp_q[$];

  ticket_payout_if bus();

  ticket_payout #(.COIN_GAP(3), .TKT_TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // Printer model: acks in the ack_at-th cycle of tkt_fire (0 = never).
  always @(negedge clk) begin
    if (bus.tkt_fire === 1'b1) begin
      fire_cnt = fire_cnt + 1;
      bus.tkt_ack = (ack_at != 0) && (fire_cnt == ack_at);
    end else begin
      fire_cnt = 0;
      bus.tkt_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int c, input logic [3:0] k);
    exp_q.push_back({k, 28'(c)});
  endtask

  task automatic observe(input logic [3:0] k);
    logic [31:0] act;
    logic [31:0] exp;
    act = {k, 28'(cyc)};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d at cycle %0d, required no event", k, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL event: got kind=%0d at cycle %0d, required kind=%0d at cycle %0d",
                 k, cyc, exp[31:28], exp[27:0]);
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.tkt_fire && !prev_tkt) observe(K_TR);
      if (!bus.tkt_fire && prev_tkt) observe(K_TF);
      if (bus.coin2_fire) observe(K_C2);
      if (bus.coin1_fire) observe(K_C1);
      if (bus.ovf) observe(K_OVF);
      if (bus.fault && !prev_fault) observe(K_FAULT);
      if (!bus.busy && prev_busy) observe(K_BF);
    end
    prev_tkt   = bus.tkt_fire;
    prev_busy  = bus.busy;
    prev_fault = bus.fault;
  end

  // Driver tasks
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events pending after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_st"}, 32'(bus.st), 32'd0);
    check({tag, "_tkt"}, 32'(bus.tkt_fire), 32'd0);
    check({tag, "_c2"}, 32'(bus.coin2_fire), 32'd0);
    check({tag, "_c1"}, 32'(bus.coin1_fire), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    check({tag, "_fault"}, 32'(bus.fault), 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    rst = 1'b1;
    bus.y = 1'b0;
    bus.re = 3'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: re=5, ack in 2nd fire cycle -> 2,2,1 coins spaced 4 cycles
    ack_at = 2;
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd5;
    exp_ev(t0 + 3, K_TR); exp_ev(t0 + 5, K_TF); exp_ev(t0 + 5, K_C2);
    exp_ev(t0 + 9, K_C2); exp_ev(t0 + 13, K_C1); exp_ev(t0 + 17, K_BF);
    exp_sales++;
    @(negedge clk);
    bus.y = 1'b0; bus.re = 3'($urandom_range(0, 7));
    check("s1_busy_queued", 32'(bus.busy), 32'd1);
    wait_to(t0 + 2);
    check("s1_st_load", 32'(bus.st), 32'd1);
    wait_to(t0 + 3);
    check("s1_st_print", 32'(bus.st), 32'd2);
    drain();
    check("s1_fault", 32'(bus.fault), 32'd0);

    // 2: re=0 -> ticket only
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd0;
    exp_ev(t0 + 3, K_TR); exp_ev(t0 + 5, K_TF); exp_ev(t0 + 5, K_BF);
    exp_sales++;
    @(negedge clk);
    bus.y = 1'b0; bus.re = 3'd7;
    drain();

    // 2b: y held high, re changes after the rise -> one 1-unit payout
    ack_at = 1;
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd1;
    exp_ev(t0 + 3, K_TR); exp_ev(t0 + 4, K_TF); exp_ev(t0 + 4, K_C1);
    exp_ev(t0 + 8, K_BF);
    exp_sales++;
    @(negedge clk);
    bus.re = 3'd6;
    wait_to(t0 + 12);
    bus.y = 1'b0;
    drain();

    // 3: three rises during a payout -> two served in order, third dropped
    ack_at = 2;
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd5;
    exp_ev(t0 + 3, K_TR);  exp_ev(t0 + 5, K_TF);  exp_ev(t0 + 5, K_C2);
    exp_ev(t0 + 9, K_C2);  exp_ev(t0 + 11, K_OVF); exp_ev(t0 + 13, K_C1);
    exp_ev(t0 + 19, K_TR); exp_ev(t0 + 21, K_TF); exp_ev(t0 + 21, K_C2);
    exp_ev(t0 + 25, K_C1); exp_ev(t0 + 31, K_TR); exp_ev(t0 + 33, K_TF);
    exp_ev(t0 + 33, K_C2); exp_ev(t0 + 37, K_BF);
    exp_sales += 3;
    @(negedge clk);
    bus.y = 1'b0;
    wait_to(t0 + 6);  bus.y = 1'b1; bus.re = 3'd3;
    wait_to(t0 + 7);  bus.y = 1'b0; bus.re = 3'd4;
    wait_to(t0 + 8);  bus.y = 1'b1; bus.re = 3'd2;
    wait_to(t0 + 9);  bus.y = 1'b0; bus.re = 3'd1;
    wait_to(t0 + 10); bus.y = 1'b1; bus.re = 3'd7;
    wait_to(t0 + 11); bus.y = 1'b0; bus.re = 3'd0;
    drain();
    check("s3_busy_idle", 32'(bus.busy), 32'd0);
`ifdef PAYOUT_SALES_COUNT_EN
    check("s3_sales", 32'(bus.sales_cnt), 32'(exp_sales));
`endif

    // 4: no ack -> 20-cycle timeout, fault, re=6 still pays 2,2,2
    ack_at = 0;
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd6;
    exp_ev(t0 + 3, K_TR);  exp_ev(t0 + 23, K_TF); exp_ev(t0 + 23, K_C2);
    exp_ev(t0 + 23, K_FAULT); exp_ev(t0 + 27, K_C2); exp_ev(t0 + 31, K_C2);
    exp_ev(t0 + 35, K_BF);
    exp_sales++;
    @(negedge clk);
    bus.y = 1'b0;
    drain();
    check("s4_fault", 32'(bus.fault), 32'd1);
    ack_at = 2;

    // 5: reset in GAP after the first coin, y held through release
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd5;
    exp_ev(t0 + 3, K_TR); exp_ev(t0 + 5, K_TF); exp_ev(t0 + 5, K_C2);
    exp_ev(t0 + 7, K_BF);
    @(negedge clk);
    bus.y = 1'b0;
    wait_to(t0 + 6);
    check("s5_st_gap", 32'(bus.st), 32'd5);
    rst = 1'b1; bus.y = 1'b1; bus.re = 3'd2;
    wait_to(t0 + 7);
    check_all_zero("s5_rst");
    exp_sales = 0;
`ifdef PAYOUT_SALES_COUNT_EN
    check("s5_sales_rst", 32'(bus.sales_cnt), 32'd0);
`endif
    rst = 1'b0;
    t1 = cyc;
    exp_ev(t1 + 3, K_TR); exp_ev(t1 + 5, K_TF); exp_ev(t1 + 5, K_C2);
    exp_ev(t1 + 9, K_BF);
    exp_sales++;
    wait_to(t1 + 4);
    bus.y = 1'b0;
    drain();

`ifdef PAYOUT_SALES_COUNT_EN
    check("s5_sales", 32'(bus.sales_cnt), 32'(exp_sales));
    force dut.sales_q = 16'hFFFF;
    @(negedge clk);
    release dut.sales_q;
    t0 = cyc;
    bus.y = 1'b1; bus.re = 3'd0;
    exp_ev(t0 + 3, K_TR); exp_ev(t0 + 5, K_TF); exp_ev(t0 + 5, K_BF);
    @(negedge clk);
    bus.y = 1'b0;
    drain();
    check("sales_sat", 32'(bus.sales_cnt), 32'h0000FFFF);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
